// File: rtl/mem_if_pkg.sv
// rtl/mem_if_pkg.sv - shared widths, size codes, owner tags and FSM states for the core memory initiator
package mem_if_pkg;

    localparam int ADDR_WIDTH             = 32;
    localparam int WORD_WIDTH             = 32;
    localparam int ICACHE_DATA_BLOCK_SIZE = 64;

    localparam logic [2:0] MEM_SIZE_BLOCK = 3'd0;
    localparam logic [2:0] MEM_SIZE_BYTE  = 3'd1;
    localparam logic [2:0] MEM_SIZE_HALF  = 3'd2;
    localparam logic [2:0] MEM_SIZE_WORD  = 3'd4;

    localparam logic OWNER_IFU = 1'b1;
    localparam logic OWNER_LSU = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } mem_state_e;

    // Load data is the low bytes of the response, zero-extended to a word.
    function automatic logic [WORD_WIDTH-1:0] lsu_extract(
        input logic [2:0]            size,
        input logic [WORD_WIDTH-1:0] word
    );
        case (size)
            MEM_SIZE_BYTE: return {{(WORD_WIDTH-8){1'b0}}, word[7:0]};
            MEM_SIZE_HALF: return {{(WORD_WIDTH-16){1'b0}}, word[15:0]};
            default:       return word;
        endcase
    endfunction

endpackage

// File: rtl/mem_rr_arb2.sv
// rtl/mem_rr_arb2.sv - two-way round-robin grant between IFU and LSU requests
module mem_rr_arb2
    import mem_if_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic ifu_req,
    input  logic lsu_req,
    output logic gnt_ifu,
    output logic gnt_lsu
);

    logic last_grant;

    // On a conflict the requester that did not win last time is served.
    always_comb begin
        gnt_ifu = en && ifu_req && (!lsu_req || (last_grant == OWNER_LSU));
        gnt_lsu = en && lsu_req && (!ifu_req || (last_grant == OWNER_IFU));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= OWNER_LSU;
        end else if (gnt_ifu) begin
            last_grant <= OWNER_IFU;
        end else if (gnt_lsu) begin
            last_grant <= OWNER_LSU;
        end
    end

endmodule

// File: rtl/core_mem_initiator.sv
// rtl/core_mem_initiator.sv - issues one IFU/LSU read at a time to main memory and routes the response back
module core_mem_initiator
    import mem_if_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ifu_req_valid,
    input  logic [ADDR_WIDTH-1:0]             ifu_req_addr,
    output logic                              ifu_req_ready,
    input  logic                              lsu_req_valid,
    input  logic [ADDR_WIDTH-1:0]             lsu_req_addr,
    input  logic [2:0]                        lsu_req_size,
    output logic                              lsu_req_ready,
    output logic                              ifu_resp_valid,
    output logic [ICACHE_DATA_BLOCK_SIZE-1:0] ifu_resp_data,
    output logic                              ifu_resp_err,
    output logic                              lsu_resp_valid,
    output logic [WORD_WIDTH-1:0]             lsu_resp_data,
    output logic                              lsu_resp_err,
    output logic                              mem_req_valid,
    output logic                              mem_req_lsu_aL_ifu_aH,
    output logic [ADDR_WIDTH-1:0]             mem_req_addr,
    output logic [2:0]                        mem_req_size,
    output logic [WORD_WIDTH-1:0]             mem_req_data,
    input  logic                              mem_resp_en,
    input  logic                              mem_resp_lsu_aL_ifu_aH,
    input  logic [ADDR_WIDTH-1:0]             mem_resp_addr,
    input  logic [2:0]                        mem_resp_size,
    input  logic [ICACHE_DATA_BLOCK_SIZE-1:0] mem_resp_data,
    output logic                              stray_resp
);

    localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT_CYCLES);

    mem_state_e            state;
    mem_state_e            next_state;
    logic                  req_owner;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [2:0]            req_size;
    logic [7:0]            wait_cnt;

    logic                  gnt_ifu;
    logic                  gnt_lsu;
    logic                  accept;
    logic                  match;
    logic                  timeout;
    logic                  sel_owner;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [2:0]            sel_size;

    mem_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .en      (state == IDLE),
        .ifu_req (ifu_req_valid),
        .lsu_req (lsu_req_valid),
        .gnt_ifu (gnt_ifu),
        .gnt_lsu (gnt_lsu)
    );

    assign ifu_req_ready = gnt_ifu;
    assign lsu_req_ready = gnt_lsu;
    assign mem_req_data  = '0;

    always_comb begin
        next_state = state;
        accept     = gnt_ifu || gnt_lsu;
        sel_owner  = gnt_ifu ? OWNER_IFU : OWNER_LSU;
        sel_addr   = gnt_ifu ? ifu_req_addr : lsu_req_addr;
        sel_size   = gnt_ifu ? MEM_SIZE_BLOCK : lsu_req_size;
        match      = (state == WAIT) && mem_resp_en
                     && (mem_resp_lsu_aL_ifu_aH == req_owner)
                     && (mem_resp_addr == req_addr)
                     && (mem_resp_size == req_size);
        // A response landing in the timeout cycle still counts as a normal delivery.
        timeout    = (state == WAIT) && !match && (wait_cnt == TIMEOUT_VAL);
        case (state)
            IDLE:    if (accept) next_state = ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (match || timeout) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= IDLE;
            wait_cnt              <= 8'd0;
            req_owner             <= OWNER_LSU;
            req_addr              <= '0;
            req_size              <= 3'd0;
            mem_req_valid         <= 1'b0;
            mem_req_lsu_aL_ifu_aH <= 1'b0;
            mem_req_addr          <= '0;
            mem_req_size          <= 3'd0;
            ifu_resp_valid        <= 1'b0;
            ifu_resp_err          <= 1'b0;
            ifu_resp_data         <= '0;
            lsu_resp_valid        <= 1'b0;
            lsu_resp_err          <= 1'b0;
            lsu_resp_data         <= '0;
            stray_resp            <= 1'b0;
        end else begin
            state <= next_state;

            if (accept) begin
                req_owner <= sel_owner;
                req_addr  <= sel_addr;
                req_size  <= sel_size;
            end

            // The memory request fields are only non-zero during the single ISSUE cycle.
            mem_req_valid         <= accept;
            mem_req_lsu_aL_ifu_aH <= accept ? sel_owner : 1'b0;
            mem_req_addr          <= accept ? sel_addr : '0;
            mem_req_size          <= accept ? sel_size : 3'd0;

            if (state == ISSUE) begin
                wait_cnt <= 8'd0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 8'd1;
            end

            ifu_resp_valid <= (match || timeout) && (req_owner == OWNER_IFU);
            ifu_resp_err   <= timeout && (req_owner == OWNER_IFU);
            ifu_resp_data  <= (match && (req_owner == OWNER_IFU)) ? mem_resp_data : '0;

            lsu_resp_valid <= (match || timeout) && (req_owner == OWNER_LSU);
            lsu_resp_err   <= timeout && (req_owner == OWNER_LSU);
            lsu_resp_data  <= (match && (req_owner == OWNER_LSU))
                              ? lsu_extract(req_size, mem_resp_data[WORD_WIDTH-1:0]) : '0;

            stray_resp <= mem_resp_en && !match;
        end
    end

endmodule

// File: tb/tb_core_mem_initiator.sv
// tb/tb_core_mem_initiator.sv - directed self-checking bench for core_mem_initiator
module tb_core_mem_initiator;
    import mem_if_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid;
    logic [31:0] ifu_req_addr;
    logic        ifu_req_ready;
    logic        lsu_req_valid;
    logic [31:0] lsu_req_addr;
    logic [2:0]  lsu_req_size;
    logic        lsu_req_ready;
    logic        ifu_resp_valid;
    logic [63:0] ifu_resp_data;
    logic        ifu_resp_err;
    logic        lsu_resp_valid;
    logic [31:0] lsu_resp_data;
    logic        lsu_resp_err;
    logic        mem_req_valid;
    logic        mem_req_lsu_aL_ifu_aH;
    logic [31:0] mem_req_addr;
    logic [2:0]  mem_req_size;
    logic [31:0] mem_req_data;
    logic        mem_resp_en;
    logic        mem_resp_lsu_aL_ifu_aH;
    logic [31:0] mem_resp_addr;
    logic [2:0]  mem_resp_size;
    logic [63:0] mem_resp_data;
    logic        stray_resp;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    core_mem_initiator #(.TIMEOUT_CYCLES(4)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .ifu_req_valid          (ifu_req_valid),
        .ifu_req_addr           (ifu_req_addr),
        .ifu_req_ready          (ifu_req_ready),
        .lsu_req_valid          (lsu_req_valid),
        .lsu_req_addr           (lsu_req_addr),
        .lsu_req_size           (lsu_req_size),
        .lsu_req_ready          (lsu_req_ready),
        .ifu_resp_valid         (ifu_resp_valid),
        .ifu_resp_data          (ifu_resp_data),
        .ifu_resp_err           (ifu_resp_err),
        .lsu_resp_valid         (lsu_resp_valid),
        .lsu_resp_data          (lsu_resp_data),
        .lsu_resp_err           (lsu_resp_err),
        .mem_req_valid          (mem_req_valid),
        .mem_req_lsu_aL_ifu_aH  (mem_req_lsu_aL_ifu_aH),
        .mem_req_addr           (mem_req_addr),
        .mem_req_size           (mem_req_size),
        .mem_req_data           (mem_req_data),
        .mem_resp_en            (mem_resp_en),
        .mem_resp_lsu_aL_ifu_aH (mem_resp_lsu_aL_ifu_aH),
        .mem_resp_addr          (mem_resp_addr),
        .mem_resp_size          (mem_resp_size),
        .mem_resp_data          (mem_resp_data),
        .stray_resp             (stray_resp)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_resp(input logic en, input logic owner, input logic [31:0] addr,
                              input logic [2:0] size, input logic [63:0] data);
        mem_resp_en            = en;
        mem_resp_lsu_aL_ifu_aH = owner;
        mem_resp_addr          = addr;
        mem_resp_size          = size;
        mem_resp_data          = data;
    endtask

    task automatic serve(input logic owner, input logic [31:0] addr, input logic [2:0] size,
                         input logic [63:0] rdata);
        #1;
        check("grant", (owner ? ifu_req_ready : lsu_req_ready), 1'b1);
        tick;
        check("req_valid", mem_req_valid, 1'b1);
        check("req_owner", mem_req_lsu_aL_ifu_aH, owner);
        check("req_addr", mem_req_addr, addr);
        check("req_size", mem_req_size, size);
        check("req_data", mem_req_data, 32'h0);
        check("busy_ready", {ifu_req_ready, lsu_req_ready}, 2'b00);
        tick;
        check("req_one_cycle", mem_req_valid, 1'b0);
        drive_resp(1'b1, owner, addr, size, rdata);
        tick;
        drive_resp(1'b0, 1'b0, 32'h0, 3'd0, 64'h0);
    endtask

    initial begin
        rst           = 1'b1;
        ifu_req_valid = 1'b0;
        ifu_req_addr  = 32'h0;
        lsu_req_valid = 1'b0;
        lsu_req_addr  = 32'h0;
        lsu_req_size  = 3'd0;
        drive_resp(1'b0, 1'b0, 32'h0, 3'd0, 64'h0);
        tick;
        tick;
        check("rst_mem_req_valid", mem_req_valid, 1'b0);
        check("rst_ifu_resp_valid", ifu_resp_valid, 1'b0);
        check("rst_lsu_resp_valid", lsu_resp_valid, 1'b0);
        check("rst_stray", stray_resp, 1'b0);
        check("rst_mem_req_addr", mem_req_addr, 32'h0);
        rst = 1'b0;

        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h100;
        #1;
        check("ifu_alone_lsu_ready", lsu_req_ready, 1'b0);
        serve(OWNER_IFU, 32'h100, MEM_SIZE_BLOCK, 64'h0807060504030201);
        check("ifu_resp_valid", ifu_resp_valid, 1'b1);
        check("ifu_resp_data", ifu_resp_data, 64'h0807060504030201);
        check("ifu_resp_err", ifu_resp_err, 1'b0);
        check("ifu_no_lsu_resp", lsu_resp_valid, 1'b0);
        check("ifu_no_stray", stray_resp, 1'b0);
        ifu_req_valid = 1'b0;
        tick;
        check("ifu_resp_pulse", ifu_resp_valid, 1'b0);

        lsu_req_valid = 1'b1;
        lsu_req_addr  = 32'h203;
        lsu_req_size  = MEM_SIZE_BYTE;
        serve(OWNER_LSU, 32'h203, MEM_SIZE_BYTE, 64'h11223344556677A5);
        check("lsu_byte_valid", lsu_resp_valid, 1'b1);
        check("lsu_byte_data", lsu_resp_data, 32'h000000A5);
        check("lsu_byte_err", lsu_resp_err, 1'b0);
        check("lsu_byte_no_ifu", ifu_resp_valid, 1'b0);
        lsu_req_addr = 32'h202;
        lsu_req_size = MEM_SIZE_HALF;
        serve(OWNER_LSU, 32'h202, MEM_SIZE_HALF, 64'hFFFFFFFFFFFFC3A5);
        check("lsu_half_data", lsu_resp_data, 32'h0000C3A5);
        lsu_req_addr = 32'h204;
        lsu_req_size = MEM_SIZE_WORD;
        serve(OWNER_LSU, 32'h204, MEM_SIZE_WORD, 64'h55555555DEADBEEF);
        check("lsu_word_data", lsu_resp_data, 32'hDEADBEEF);
        lsu_req_valid = 1'b0;
        tick;

        rst = 1'b1;
        tick;
        rst = 1'b0;
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h600;
        lsu_req_valid = 1'b1;
        lsu_req_addr  = 32'h700;
        lsu_req_size  = MEM_SIZE_WORD;
        #1;
        check("conflict1_lsu_blocked", lsu_req_ready, 1'b0);
        serve(OWNER_IFU, 32'h600, MEM_SIZE_BLOCK, 64'h00000000000000A1);
        check("conflict1_ifu_resp", ifu_resp_valid, 1'b1);
        #1;
        check("conflict2_ifu_blocked", ifu_req_ready, 1'b0);
        serve(OWNER_LSU, 32'h700, MEM_SIZE_WORD, 64'h0000000012345678);
        check("conflict2_lsu_resp", lsu_resp_valid, 1'b1);
        check("conflict2_lsu_data", lsu_resp_data, 32'h12345678);
        #1;
        check("conflict3_lsu_blocked", lsu_req_ready, 1'b0);
        serve(OWNER_IFU, 32'h600, MEM_SIZE_BLOCK, 64'h00000000000000B2);
        check("conflict3_ifu_data", ifu_resp_data, 64'h00000000000000B2);
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        tick;

        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h400;
        tick;
        ifu_req_valid = 1'b0;
        check("to_issue", mem_req_valid, 1'b1);
        repeat (5) tick;
        check("to_not_early", ifu_resp_valid, 1'b0);
        tick;
        check("to_valid", ifu_resp_valid, 1'b1);
        check("to_err", ifu_resp_err, 1'b1);
        check("to_data", ifu_resp_data, 64'h0);
        check("to_no_lsu", lsu_resp_valid, 1'b0);
        drive_resp(1'b1, OWNER_IFU, 32'h400, MEM_SIZE_BLOCK, 64'h1234);
        tick;
        drive_resp(1'b0, 1'b0, 32'h0, 3'd0, 64'h0);
        check("late_stray", stray_resp, 1'b1);
        check("late_no_resp", ifu_resp_valid, 1'b0);
        tick;
        check("late_stray_pulse", stray_resp, 1'b0);

        lsu_req_valid = 1'b1;
        lsu_req_addr  = 32'h300;
        lsu_req_size  = MEM_SIZE_WORD;
        tick;
        lsu_req_valid = 1'b0;
        tick;
        drive_resp(1'b1, OWNER_LSU, 32'h304, MEM_SIZE_WORD, 64'h0BADF00D);
        tick;
        check("wrong_addr_stray", stray_resp, 1'b1);
        check("wrong_addr_no_resp", lsu_resp_valid, 1'b0);
        drive_resp(1'b1, OWNER_LSU, 32'h300, MEM_SIZE_WORD, 64'h0BADF00D);
        tick;
        drive_resp(1'b0, 1'b0, 32'h0, 3'd0, 64'h0);
        check("right_addr_valid", lsu_resp_valid, 1'b1);
        check("right_addr_data", lsu_resp_data, 32'h0BADF00D);
        check("right_addr_err", lsu_resp_err, 1'b0);
        check("right_addr_no_stray", stray_resp, 1'b0);
        tick;

        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h500;
        tick;
        ifu_req_valid = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("rst_wait_mem_req", mem_req_valid, 1'b0);
        check("rst_wait_ifu_resp", ifu_resp_valid, 1'b0);
        check("rst_wait_lsu_resp", lsu_resp_valid, 1'b0);
        drive_resp(1'b1, OWNER_IFU, 32'h500, MEM_SIZE_BLOCK, 64'h55);
        tick;
        drive_resp(1'b0, 1'b0, 32'h0, 3'd0, 64'h0);
        check("rst_wait_stray", stray_resp, 1'b1);
        check("rst_wait_no_resp", ifu_resp_valid, 1'b0);
        ifu_req_valid = 1'b1;
        #1;
        check("rst_wait_idle_ready", ifu_req_ready, 1'b1);
        ifu_req_valid = 1'b0;
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
